// File: rtl/bitonic_sort_pipe.sv
// Pipelined bitonic sorting network: one registered compare-exchange layer per stage, valid/ready flow control.
// Define BITONIC_SORT_DIR_EN to add in_desc, which selects descending order per vector.

module bitonic_cx #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         up,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);
  logic swap;

  // Strict compares so equal operands never swap.
  assign swap = up ? (a > b) : (a < b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;
endmodule

module bitonic_sort_pipe #(
  parameter int W     = 4,
  parameter int LOG_N = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [(1<<LOG_N)*W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [(1<<LOG_N)*W-1:0]   out_data,
  output logic                      busy
`ifdef BITONIC_SORT_DIR_EN
  ,
  input  logic                      in_desc
`endif
);
  localparam int N = 1 << LOG_N;
  localparam int S = LOG_N * (LOG_N + 1) / 2;

  logic                          adv;
  logic                          in_desc_i;
  logic [S:1]                    vld_q;
  logic [S:0]                    vld_pipe;
  logic [S-1:0]                  desc_pipe;
  logic [S:1][N-1:0][W-1:0]      stg_q;
  logic [S-1:0][N-1:0][W-1:0]    nxt;

`ifdef BITONIC_SORT_DIR_EN
  assign in_desc_i = in_desc;
`else
  assign in_desc_i = 1'b0;
`endif

  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign vld_pipe  = {vld_q, in_valid};
  assign out_valid = vld_q[S];
  assign busy      = |vld_q;
  assign out_data  = stg_q[S];

  // Direction bit rides alongside the data; the last stage has no consumer for it.
  assign desc_pipe[0] = in_desc_i;
  if (S > 1) begin : g_desc
    logic [S-1:1] desc_q;
    always_ff @(posedge clk)
      if (adv) desc_q <= desc_pipe[S-2:0];
    assign desc_pipe[S-1:1] = desc_q;
  end

  // Block size 2^k, compare distance 2^J from k-1 down to 0; stage index ST is the flat layer number.
  for (genvar k = 1; k <= LOG_N; k++) begin : g_blk
    for (genvar jj = 0; jj < k; jj++) begin : g_lyr
      localparam int J  = k - 1 - jj;
      localparam int ST = (k - 1) * k / 2 + jj;
      logic [N-1:0][W-1:0] sin;

      if (ST == 0) begin : g_src_in
        assign sin = in_data;
      end else begin : g_src_reg
        assign sin = stg_q[ST];
      end

      for (genvar p = 0; p < N / 2; p++) begin : g_cx
        localparam int I   = ((p >> J) << (J + 1)) | (p & ((1 << J) - 1));
        localparam int L   = I | (1 << J);
        localparam bit ASC = ((I >> k) & 1) == 0;
        bitonic_cx #(.W(W)) u_cx (
          .a  (sin[I]),
          .b  (sin[L]),
          .up (ASC ^ desc_pipe[ST]),
          .lo (nxt[ST][I]),
          .hi (nxt[ST][L])
        );
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   vld_q <= '0;
    else if (adv) vld_q <= vld_pipe[S-1:0];

  // Data needs no reset: the valid bits alone decide what is presented.
  always_ff @(posedge clk)
    if (adv) stg_q <= nxt;
endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Self-checking bench for bitonic_sort_pipe (N=4, W=4): directed spec vectors plus random traffic vs a sort model.
module tb_bitonic_sort_pipe;
  localparam int W = 4, LOG_N = 2, N = 4, S = 3, DW = N * W;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0, tb_desc = 1'b0;
  logic          in_ready, out_valid, busy;
  logic [DW-1:0] in_data = '0, out_data;

  logic [DW-1:0] exp_q[$];
  logic          s_ov, s_ir, s_busy;
  logic [DW-1:0] s_od, held, e;
  int            n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  bitonic_sort_pipe #(.W(W), .LOG_N(LOG_N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
`ifdef BITONIC_SORT_DIR_EN
    , .in_desc(tb_desc)
`endif
  );

  function automatic logic [DW-1:0] sort_ref(input logic [DW-1:0] v, input logic d);
    int q[$];
    logic [DW-1:0] r;
    for (int i = 0; i < N; i++) q.push_back(int'(v[i*W +: W]));
    q.sort();
    if (d) q.reverse();
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = q[i][W-1:0];
    return r;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, score handshakes, return 1 time unit after the rising edge.
  task automatic cyc();
    @(negedge clk);
    s_ov = out_valid; s_od = out_data; s_ir = in_ready; s_busy = busy;
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(sort_ref(in_data, tb_desc));
      if (out_valid && out_ready) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_bad++;
          $error("FAIL sb_extra: observed %h expected no output", out_data);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_data", out_data, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) cyc();
    check1("rst_out_valid", s_ov, 1'b0);
    check1("rst_busy", s_busy, 1'b0);
    check1("rst_in_ready", s_ir, 1'b1);
    rst_n = 1'b1; out_ready = 1'b1;

    // basic sort and latency
    in_valid = 1'b1; in_data = 16'h0213; cyc();
    check1("first_accept", s_ir, 1'b1);
    in_valid = 1'b0;
    cyc(); check1("lat_c1", s_ov, 1'b0);
    cyc(); check1("lat_c2", s_ov, 1'b0);
    cyc(); check1("basic_valid", s_ov, 1'b1);
    check("basic_data", s_od, 16'h3210);

    // duplicates and extremes
    in_valid = 1'b1; in_data = 16'h0F0F; cyc();
    in_data = 16'h7777; cyc();
    in_valid = 1'b0; cyc(); cyc();
    check1("dup1_valid", s_ov, 1'b1);
    check("dup1_data", s_od, 16'hFF00);
    cyc();
    check1("dup2_valid", s_ov, 1'b1);
    check("dup2_data", s_od, 16'h7777);
    cyc();

    // full throughput
    for (int i = 0; i < 8 + S; i++) begin
      if (i < 8) begin in_valid = 1'b1; in_data = DW'($urandom); end
      else in_valid = 1'b0;
      cyc();
      if (i < 8) check1("tput_in_ready", s_ir, 1'b1);
      if (i >= S) check1("tput_out_valid", s_ov, 1'b1);
    end
    cyc(); check1("tput_end", s_ov, 1'b0);

    // backpressure with a full pipeline
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < S; i++) begin
      in_data = DW'($urandom); cyc();
      check1("bp_fill_ready", s_ir, 1'b1);
    end
    in_data = DW'($urandom); cyc();
    held = s_od;
    check1("bp_full_valid", s_ov, 1'b1);
    check1("bp_full_ready", s_ir, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_data = DW'($urandom); cyc();
      check1("bp_ready", s_ir, 1'b0);
      check("bp_hold", s_od, held);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < S + 2; i++) cyc();
    check("bp_drained", DW'(exp_q.size()), DW'(0));
    check1("bp_busy", s_busy, 1'b0);

    // reset with three vectors in flight
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin in_data = DW'($urandom); cyc(); end
    in_valid = 1'b0;
    check1("rstmid_pre", out_valid, 1'b1);
    rst_n = 1'b0; #1;
    check1("rstmid_ov", out_valid, 1'b0);
    check1("rstmid_busy", busy, 1'b0);
    exp_q.delete();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin cyc(); check1("no_stale", s_ov, 1'b0); end

`ifdef BITONIC_SORT_DIR_EN
    // mixed direction back to back
    in_valid = 1'b1; in_data = 16'h0213; tb_desc = 1'b1; cyc();
    tb_desc = 1'b0; cyc();
    in_valid = 1'b0; cyc(); cyc();
    check("mix_desc", s_od, 16'h0123);
    cyc();
    check("mix_asc", s_od, 16'h3210);
`endif

    // random traffic
    for (int i = 0; i < 80; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef BITONIC_SORT_DIR_EN
      tb_desc   = 1'($urandom_range(0, 1));
`endif
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    cyc();
    check("final_empty", DW'(exp_q.size()), DW'(0));
    check1("final_busy", s_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
